multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps over several clocks. It replaces the single-cycle combinational decoder and drives the shared-ALU/shared-memory datapath: PC, IR, register file, ALU source muxes and unified memory. It adds a memory ready handshake with wait states, a bounded-wait timeout, illegal-opcode detection and an instruction-retired pulse.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = memory states wait for `memReady`; 0 = memory is treated as always ready and `memReady` is ignored.
- `MEM_TIMEOUT`, default 15: maximum wait cycles in one memory state before abort; 0 disables the timeout.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE onward.
- `funct`  in  6  IR[5:0].
- `memReady`  in  1  memory has completed the current read or write.
- `pcWrite`, `pcWriteCond`, `branchNe`  out  1 each  unconditional PC load; PC load conditioned on the ALU zero flag; invert the zero condition (bne).
- `iorD`, `memRead`, `memWrite`, `irWrite`  out  1 each  address select (0 = PC, 1 = ALUOut); memory read strobe; memory write strobe; IR load.
- `regDst`, `memToReg`, `regWrite`  out  1 each  write-back controls, with the same meaning as in the single-cycle unit.
- `aluSrcA`  out  1  0 = PC, 1 = register A.
- `aluSrcB`  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `aluOp`  out  2  00 = add, 01 = subtract, 10 = use `funct`.
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A (jr).
- `illegalOp`, `memFault`, `instrDone`  out  1 each  one-cycle status pulses.
- `state`  out  4  current state encoding, for debug.

## Operation
- Every output not listed for a state is 0.
- **FETCH (0):**
  - Drives `memRead`=1, `iorD`=0, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=00, `pcSource`=00.
  - `irWrite` and `pcWrite` equal the effective ready signal.
  - Moves to DECODE when ready is seen.
- **DECODE (1):** drives `aluSrcB`=11, `aluOp`=00. Next state by opcode:
  - opcode 0 with `funct`=8 goes to JR.
  - Any other opcode 0 goes to EXEC.
  - 35 or 43 goes to MEMADR.
  - 4 or 5 goes to BRANCH.
  - 8 goes to ADDIEXE.
  - 2 goes to JUMP.
  - Anything else goes to FETCH, with `illegalOp`=1 in this cycle.
- **MEMADR (2):** drives `aluSrcA`=1, `aluSrcB`=10. Goes to MEMRD if opcode is 35, otherwise MEMWR.
- **MEMRD (3):** drives `memRead`=1, `iorD`=1. Goes to MEMWB on ready.
- **MEMWB (4):** drives `memToReg`=1, `regWrite`=1. Returns to FETCH.
- **MEMWR (5):** drives `memWrite`=1, `iorD`=1. Returns to FETCH on ready.
- **EXEC (6):** drives `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10. Goes to RTYPEWB.
- **RTYPEWB (7):** drives `regDst`=1, `regWrite`=1. Returns to FETCH.
- **BRANCH (8):** drives `aluSrcA`=1, `aluOp`=01, `pcWriteCond`=1, `pcSource`=01, and `branchNe`=(opcode==5). Returns to FETCH.
- **ADDIEXE (9):** drives `aluSrcA`=1, `aluSrcB`=10. Goes to ADDIWB.
- **ADDIWB (10):** drives `regWrite`=1. Returns to FETCH.
- **JUMP (11):** drives `pcWrite`=1, `pcSource`=10. Returns to FETCH.
- **JR (12):** drives `pcWrite`=1, `pcSource`=11. Returns to FETCH. `regWrite` stays 0.
- **Effective ready** is `memReady` when `MEM_HANDSHAKE`=1, and constant 1 when `MEM_HANDSHAKE`=0.
- **Wait counter:**
  - Counts cycles spent in FETCH, MEMRD or MEMWR without ready.
  - Cleared on every state change.
- **Timeout abort:**
  - Triggers when the counter reaches `MEM_TIMEOUT` and ready is still 0.
  - The unit pulses `memFault`, goes to FETCH, and asserts no write strobe in that cycle.
  - In FETCH, the abort retries the fetch.
- **instrDone:**
  - Pulses in the last cycle of every completed instruction, i.e. any state whose next state is FETCH.
  - Not asserted on an illegal opcode or a timeout abort.
- **Unused encodings 13–15** go to FETCH with all outputs 0.

## Timing
- **Reset:**
  - While `rst_n`=0, state = FETCH, the wait counter is 0, and every output is forced to 0, including `state`.
  - An asynchronous assert mid-instruction aborts it immediately; no partial write strobe remains.
  - After release, the first fetch starts on the next edge.
- **Outputs:** Moore decode of the state register. The only Mealy terms are the ready-qualified `irWrite`/`pcWrite` in FETCH and the strobes cut on abort.
- **Zero-wait latencies:** R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3, jr 3 cycles. Each wait cycle adds 1.
- **`memReady` in the same cycle the state is entered** counts as ready (zero wait).
- **Simultaneous timeout and ready:** ready wins, and there is no fault.

## Structure
- **Shared package `mips_ctrl_pkg`:**
  - State encodings.
  - Opcode constants (RTYPE=0, J=2, BEQ=4, BNE=5, ADDI=8, LW=35, SW=43) and FUNCT_JR=8.
  - The `aluOp`, `aluSrcB` and `pcSource` codes, shared with the ALU control and the datapath.
- **Sub-module `mem_wait_timer`:** the wait counter, with width $clog2(MEM_TIMEOUT+1) and a minimum of 1. It outputs `expired`.
- The state register, next-state logic and output decode stay in this module.

## Test plan
- **Reset:** hold `rst_n`=0 mid-MEMWR with `memReady`=0 → all outputs 0 immediately; after release, `state`=0.
- **lw, zero wait:** opcode 35, `memReady`=1 → states 0,1,2,3,4; `regWrite`=`memToReg`=1 in cycle 5; `instrDone` in cycle 5 only.
- **sw with 3 wait cycles:** `memReady` low for 3 cycles in MEMWR → `memWrite` high 4 cycles; 7 cycles total.
- **bne / jr:**
  - opcode 5 → `branchNe`=1, `pcWriteCond`=1, `pcSource`=01 in cycle 3.
  - opcode 0 with `funct`=8 → `pcSource`=11, `regWrite` never 1.
- **Illegal opcode:** opcode 63 → `illegalOp` pulses in DECODE, `state` returns to 0, no `instrDone`.
- **Timeout:** `MEM_TIMEOUT`=4, `memReady` stuck 0 in MEMRD → `memFault` after 4 wait cycles, state = FETCH, no `regWrite`. With `MEM_HANDSHAKE`=0, the same stimulus completes in 5 cycles.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// opcode constants and the datapath select codes used by ALU control and datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEXE = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FUNCT_JR = 6'd8;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
    logic       memFault;
    logic       instrDone;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle. Handshake: memReady high in a memory state
// means the current access has completed; it is sampled on the rising edge.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       memReady;
  logic       pcWrite, pcWriteCond, branchNe;
  logic       iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic       illegalOp, memFault, instrDone;
  logic [3:0] state;

  modport master (
    input  opcode, funct, memReady,
    output pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           illegalOp, memFault, instrDone, state
  );

  modport slave (
    output opcode, funct, memReady,
    input  pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           illegalOp, memFault, instrDone, state
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory state; expired_o flags the abort point.
// MEM_TIMEOUT = 0 disables expiry entirely.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);
  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at LIMIT so a disabled timeout never wraps into a false expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: Moore decode of state_q, plus ready-qualified
// IR/PC loads in FETCH and strobe suppression on a memory timeout abort.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_if.master        bus
);
  state_e state_q, state_d;
  ctrl_t  c;
  logic   ready_eff, stalled, expired, abort;

  assign ready_eff = (MEM_HANDSHAKE != 0) ? bus.memReady : 1'b1;
  assign stalled   = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !ready_eff;
  assign abort     = stalled && expired;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    ((state_d != state_q) || abort),
    .count_en_i (stalled),
    .expired_o  (expired)
  );

  always_comb begin
    state_d = S_FETCH;
    c       = '0;
    unique case (state_q)
      S_FETCH: begin
        c.memRead = 1'b1;
        c.aluSrcB = ALUB_FOUR;
        c.irWrite = ready_eff;
        c.pcWrite = ready_eff;
        state_d   = ready_eff ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        c.aluSrcB = ALUB_IMM_SH2;
        if (bus.opcode == OP_RTYPE) begin
          state_d = (bus.funct == FUNCT_JR) ? S_JR : S_EXEC;
        end else if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) begin
          state_d = S_BRANCH;
        end else if (bus.opcode == OP_ADDI) begin
          state_d = S_ADDIEXE;
        end else if (bus.opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
          c.illegalOp = 1'b1;
        end
      end
      S_MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = ALUB_IMM;
        state_d   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
        state_d   = ready_eff ? S_MEMWB : (abort ? S_FETCH : S_MEMRD);
      end
      S_MEMWB: begin
        c.memToReg  = 1'b1;
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      S_MEMWR: begin
        c.memWrite  = 1'b1;
        c.iorD      = 1'b1;
        c.instrDone = ready_eff;
        state_d     = (ready_eff || abort) ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = ALUB_REG;
        c.aluOp   = ALUOP_FUNCT;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        c.regDst    = 1'b1;
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      S_BRANCH: begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = ALUOP_SUB;
        c.pcWriteCond = 1'b1;
        c.pcSource    = PCSRC_ALUOUT;
        c.branchNe    = (bus.opcode == OP_BNE);
        c.instrDone   = 1'b1;
      end
      S_ADDIEXE: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = ALUB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      S_JUMP: begin
        c.pcWrite   = 1'b1;
        c.pcSource  = PCSRC_JUMP;
        c.instrDone = 1'b1;
      end
      S_JR: begin
        c.pcWrite   = 1'b1;
        c.pcSource  = PCSRC_REGA;
        c.instrDone = 1'b1;
      end
      default: ;
    endcase
    // An abort must leave no write strobe behind, and reset silences everything.
    if (abort) begin
      c.memWrite = 1'b0;
      c.memFault = 1'b1;
    end
    if (!rst_n) begin
      c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.pcWrite     = c.pcWrite;
  assign bus.pcWriteCond = c.pcWriteCond;
  assign bus.branchNe    = c.branchNe;
  assign bus.iorD        = c.iorD;
  assign bus.memRead     = c.memRead;
  assign bus.memWrite    = c.memWrite;
  assign bus.irWrite     = c.irWrite;
  assign bus.regDst      = c.regDst;
  assign bus.memToReg    = c.memToReg;
  assign bus.regWrite    = c.regWrite;
  assign bus.aluSrcA     = c.aluSrcA;
  assign bus.aluSrcB     = c.aluSrcB;
  assign bus.aluOp       = c.aluOp;
  assign bus.pcSource    = c.pcSource;
  assign bus.illegalOp   = c.illegalOp;
  assign bus.memFault    = c.memFault;
  assign bus.instrDone   = c.instrDone;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three parameterisations share stimulus;
// per-cycle expected output vectors are queued and compared at the falling edge.
module tb_multicycle_control;
  logic clk;
  logic rst_n;

  multicycle_control_if bus0 ();
  multicycle_control_if bus1 ();
  multicycle_control_if bus2 ();

  multicycle_control #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(15)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_control #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  multicycle_control #(.MEM_HANDSHAKE(0), .MEM_TIMEOUT(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] DONE = 3'b001;
  localparam logic [2:0] FLT  = 3'b010;
  localparam logic [2:0] ILL  = 3'b100;

  logic [23:0] obs0, obs1, obs2;
  assign obs0 = {bus0.state, bus0.pcWrite, bus0.pcWriteCond, bus0.branchNe, bus0.iorD,
                 bus0.memRead, bus0.memWrite, bus0.irWrite, bus0.regDst, bus0.memToReg,
                 bus0.regWrite, bus0.aluSrcA, bus0.aluSrcB, bus0.aluOp, bus0.pcSource,
                 bus0.illegalOp, bus0.memFault, bus0.instrDone};
  assign obs1 = {bus1.state, bus1.pcWrite, bus1.pcWriteCond, bus1.branchNe, bus1.iorD,
                 bus1.memRead, bus1.memWrite, bus1.irWrite, bus1.regDst, bus1.memToReg,
                 bus1.regWrite, bus1.aluSrcA, bus1.aluSrcB, bus1.aluOp, bus1.pcSource,
                 bus1.illegalOp, bus1.memFault, bus1.instrDone};
  assign obs2 = {bus2.state, bus2.pcWrite, bus2.pcWriteCond, bus2.branchNe, bus2.iorD,
                 bus2.memRead, bus2.memWrite, bus2.irWrite, bus2.regDst, bus2.memToReg,
                 bus2.regWrite, bus2.aluSrcA, bus2.aluSrcB, bus2.aluOp, bus2.pcSource,
                 bus2.illegalOp, bus2.memFault, bus2.instrDone};

  logic [23:0] exp_q[$];
  logic        rdy_q[$];
  int          checks = 0;
  int          errors = 0;

  // Output table for each state as the control unit is documented to drive it.
  function automatic logic [23:0] exp_vec(input logic [3:0] st, input logic rdy,
                                          input logic bne, input logic [2:0] flags);
    logic pw, pwc, bn, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, bn, iord, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin mwr = !flags[1]; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rdst = 1; rw = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; bn = bne; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pw = 1; psrc = 2'b10; end
      4'd12: begin pw = 1; psrc = 2'b11; end
      default: ;
    endcase
    return {st, pw, pwc, bn, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, flags};
  endfunction

  task automatic set_inputs(input logic [5:0] op, input logic [5:0] fn);
    bus0.opcode = op; bus1.opcode = op; bus2.opcode = op;
    bus0.funct  = fn; bus1.funct  = fn; bus2.funct  = fn;
  endtask

  task automatic drive_ready(input logic r);
    bus0.memReady = r; bus1.memReady = r; bus2.memReady = r;
  endtask

  // drv: memReady driven this cycle; eff: ready the DUT under test should act on.
  task automatic push(input logic [3:0] st, input logic drv, input logic eff,
                      input logic bne, input logic [2:0] flags);
    exp_q.push_back(exp_vec(st, eff, bne, flags));
    rdy_q.push_back(drv);
  endtask

  task automatic check(input int sel, input string tag, input logic [23:0] exp);
    logic [23:0] obs;
    obs = (sel == 0) ? obs0 : ((sel == 1) ? obs1 : obs2);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, sel, obs, exp);
    end
  endtask

  // Drains the scoreboard one clock per entry; entered and left at posedge+1.
  task automatic run(input int sel, input string tag);
    while (exp_q.size() > 0) begin
      drive_ready(rdy_q.pop_front());
      @(negedge clk);
      check(sel, tag, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_inputs(6'd0, 6'd0);
    drive_ready(1'b1);
    @(posedge clk);
    #1;
    check(0, "reset_hold", 24'h0);
    check(1, "reset_hold", 24'h0);
    check(2, "reset_hold", 24'h0);
    rst_n = 1'b1;

    // lw, zero wait: 5 cycles, write-back and instrDone in the last only
    set_inputs(6'd35, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 1, 1, 0, NONE); push(2, 1, 1, 0, NONE);
    push(3, 1, 1, 0, NONE); push(4, 1, 1, 0, DONE);
    run(0, "lw");

    // sw with three wait cycles in MEMWR: 7 cycles total
    set_inputs(6'd43, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 0, 0, 0, NONE); push(2, 0, 0, 0, NONE);
    push(5, 0, 0, 0, NONE); push(5, 0, 0, 0, NONE); push(5, 0, 0, 0, NONE);
    push(5, 1, 1, 0, DONE);
    run(0, "sw_wait");

    set_inputs(6'd5, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 1, 1, 0, NONE); push(8, 1, 1, 1, DONE);
    run(0, "bne");
    set_inputs(6'd4, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 1, 1, 0, NONE); push(8, 1, 1, 0, DONE);
    run(0, "beq");
    set_inputs(6'd0, 6'd8);
    push(0, 1, 1, 0, NONE); push(1, 1, 1, 0, NONE); push(12, 1, 1, 0, DONE);
    run(0, "jr");
    set_inputs(6'd0, 6'd32);
    push(0, 1, 1, 0, NONE); push(1, 1, 1, 0, NONE); push(6, 1, 1, 0, NONE);
    push(7, 1, 1, 0, DONE);
    run(0, "rtype");
    set_inputs(6'd2, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 1, 1, 0, NONE); push(11, 1, 1, 0, DONE);
    run(0, "jump");
    set_inputs(6'd8, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 1, 1, 0, NONE); push(9, 1, 1, 0, NONE);
    push(10, 1, 1, 0, DONE);
    run(0, "addi");

    // illegal opcode back to FETCH, then fetch stalls without memReady
    set_inputs(6'd63, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 1, 1, 0, ILL); push(0, 0, 0, 0, NONE);
    push(0, 0, 0, 0, NONE);
    run(0, "illegal");

    // lw timeout with MEM_TIMEOUT=4: fault on the fifth MEMRD cycle
    pulse_reset();
    set_inputs(6'd35, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 0, 0, 0, NONE); push(2, 0, 0, 0, NONE);
    push(3, 0, 0, 0, NONE); push(3, 0, 0, 0, NONE); push(3, 0, 0, 0, NONE);
    push(3, 0, 0, 0, NONE); push(3, 0, 0, 0, FLT); push(0, 0, 0, 0, NONE);
    run(1, "lw_timeout");

    // same stimulus with the handshake disabled completes in 5 cycles
    pulse_reset();
    push(0, 0, 1, 0, NONE); push(1, 0, 1, 0, NONE); push(2, 0, 1, 0, NONE);
    push(3, 0, 1, 0, NONE); push(4, 0, 1, 0, DONE);
    run(2, "lw_nohs");

    // ready arriving exactly at the timeout point wins over the abort
    pulse_reset();
    set_inputs(6'd43, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 0, 0, 0, NONE); push(2, 0, 0, 0, NONE);
    push(5, 0, 0, 0, NONE); push(5, 0, 0, 0, NONE); push(5, 0, 0, 0, NONE);
    push(5, 0, 0, 0, NONE); push(5, 1, 1, 0, DONE);
    run(1, "sw_ready_at_limit");

    // fetch timeout retries the fetch, then a jump completes normally
    set_inputs(6'd2, 6'd0);
    push(0, 0, 0, 0, NONE); push(0, 0, 0, 0, NONE); push(0, 0, 0, 0, NONE);
    push(0, 0, 0, 0, NONE); push(0, 0, 0, 0, FLT); push(0, 1, 1, 0, NONE);
    push(1, 0, 0, 0, NONE); push(11, 0, 0, 0, DONE);
    run(1, "fetch_timeout");

    // asynchronous reset in the middle of a stalled store
    pulse_reset();
    set_inputs(6'd43, 6'd0);
    push(0, 1, 1, 0, NONE); push(1, 0, 0, 0, NONE); push(2, 0, 0, 0, NONE);
    push(5, 0, 0, 0, NONE);
    run(0, "sw_pre_reset");
    drive_ready(1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check(0, "reset_async", 24'h0);
    @(posedge clk);
    #1;
    check(0, "reset_held", 24'h0);
    rst_n = 1'b1;
    #1;
    check(0, "reset_release", exp_vec(4'd0, 1'b0, 1'b0, NONE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
